calc_entrada_bcd: RTL and testbench

- Keypad-side operand/operation sequencer for the BCD calculator datapath.
- Turns one-cycle key events into BCD operands `numero_1` and `numero_2`, an operation code `suma_resta`, and a one-cycle `igual_en` strobe that drives the BCD add/subtract unit.
- Captures the returned `resultado`/`operacion_valida` for display and for chained operations.
- Sits between the keypad scanner and the arithmetic unit.

---
 rtl/calc_entrada_bcd.sv | 119 +++++++++++
 tb/tb_calc_entrada_bcd.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/calc_entrada_bcd.sv
// calc_entrada_bcd: keypad operand/operation sequencer feeding the BCD add/subtract unit
module calc_entrada_bcd #(
   parameter int N_DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic [4*N_DIGITS-1:0] resultado,
   input  logic                  operacion_valida,
   output logic [4*N_DIGITS-1:0] numero_1,
   output logic [4*N_DIGITS-1:0] numero_2,
   output logic [1:0]            suma_resta,
   output logic                  igual_en,
   output logic [4*N_DIGITS-1:0] display,
   output logic                  error,
   output logic                  busy
);
   localparam int W  = 4*N_DIGITS;
   localparam int CW = $clog2(N_DIGITS+1);
   typedef enum logic [2:0] {ENTER_A, ENTER_B, ISSUE, WAIT, DONE} state_t;
   state_t        state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  capturado;
   logic          is_digit, is_op, is_eq, is_clr, room;
   logic [1:0]    op_code;
   logic [W-1:0]  n1_sh, n2_sh;
   assign is_digit = key_valid && key_code <= 4'd9;
   assign is_op    = key_valid && (key_code == 4'd10 || key_code == 4'd11);
   assign is_eq    = key_valid && key_code == 4'd12;
   assign is_clr   = key_valid && key_code == 4'd13;
   assign room     = cnt < CW'(N_DIGITS);
   assign op_code  = {1'b1, key_code[0]};
   assign n1_sh    = {numero_1[W-5:0], key_code};
   assign n2_sh    = {numero_2[W-5:0], key_code};
   // sequencer: operand entry, compute strobe, result capture; display tracks the active value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ENTER_A;
         cnt        <= '0;
         capturado  <= '0;
         numero_1   <= '0;
         numero_2   <= '0;
         suma_resta <= 2'b00;
         igual_en   <= 1'b0;
         display    <= '0;
         error      <= 1'b0;
         busy       <= 1'b0;
      end else if (is_clr) begin
         state      <= ENTER_A;
         cnt        <= '0;
         capturado  <= '0;
         numero_1   <= '0;
         numero_2   <= '0;
         suma_resta <= 2'b00;
         igual_en   <= 1'b0;
         display    <= '0;
         error      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         igual_en <= 1'b0;
         case (state)
            ENTER_A:
               if (is_digit && room) begin
                  numero_1 <= n1_sh;
                  display  <= n1_sh;
                  cnt      <= cnt + 1'b1;
               end else if (is_op) begin
                  suma_resta <= op_code;
                  numero_2   <= '0;
                  display    <= '0;
                  cnt        <= '0;
                  state      <= ENTER_B;
               end
            ENTER_B:
               if (is_digit && room) begin
                  numero_2 <= n2_sh;
                  display  <= n2_sh;
                  cnt      <= cnt + 1'b1;
               end else if (is_op) begin
                  suma_resta <= op_code;
               end else if (is_eq) begin
                  igual_en <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            ISSUE: state <= WAIT;
            WAIT: begin
               capturado <= resultado;
               error     <= ~operacion_valida;
               display   <= operacion_valida ? resultado : '1;
               busy      <= 1'b0;
               state     <= DONE;
            end
            DONE:
               if (is_digit) begin
                  numero_1 <= W'(key_code);
                  display  <= W'(key_code);
                  numero_2 <= '0;
                  cnt      <= CW'(1);
                  error    <= 1'b0;
                  state    <= ENTER_A;
               end else if (is_op && !error) begin
                  numero_1   <= capturado;
                  numero_2   <= '0;
                  display    <= '0;
                  suma_resta <= op_code;
                  cnt        <= '0;
                  state      <= ENTER_B;
               end else if (is_eq) begin
                  igual_en <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ISSUE;
               end
            default: state <= ENTER_A;
         endcase
      end
   end
endmodule

// File: tb/tb_calc_entrada_bcd.sv
// tb_calc_entrada_bcd: randomized and directed check against a decimal-arithmetic reference model
module tb_calc_entrada_bcd;
   localparam int N = 4;
   localparam int W = 4*N;
   logic         clk = 1'b0;
   logic         reset, key_valid, operacion_valida;
   logic [3:0]   key_code;
   logic [W-1:0] resultado, numero_1, numero_2, display;
   logic [1:0]   suma_resta;
   logic         igual_en, error, busy;
   int n_checks = 0, n_fail = 0;
   int m_a, m_b, m_na, m_op, m_mode, m_busy, m_cap, m_res;
   bit m_err, m_strobe;
   logic [W-1:0] m_disp;

   calc_entrada_bcd #(.N_DIGITS(N)) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .resultado(resultado), .operacion_valida(operacion_valida),
      .numero_1(numero_1), .numero_2(numero_2), .suma_resta(suma_resta),
      .igual_en(igual_en), .display(display), .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_a = 0; m_b = 0; m_na = 0; m_op = 0; m_mode = 0; m_busy = 0; m_cap = 0;
      m_err = 0; m_strobe = 0; m_disp = '0;
   endtask

   // mode 0: entering A, 1: entering B, 2: result shown; m_busy counts the ISSUE/WAIT cycles left
   task automatic model_step(input logic kv, input logic [3:0] code);
      bit dig, pm, eq;
      dig = kv && code <= 9;
      pm  = kv && (code == 10 || code == 11);
      eq  = kv && code == 12;
      if (kv && code == 13) model_clear();
      else if (m_busy == 2) begin m_busy = 1; m_strobe = 0; end
      else if (m_busy == 1) begin
         m_busy = 0; m_cap = m_res; m_err = !operacion_valida; m_mode = 2;
      end else begin
         m_strobe = 0;
         if (m_mode == 0) begin
            if (dig && m_na < N) begin m_a = m_a*10 + int'(code); m_na++; end
            else if (pm) begin m_op = int'(code) - 9; m_b = 0; m_na = 0; m_mode = 1; end
         end else if (m_mode == 1) begin
            if (dig && m_na < N) begin m_b = m_b*10 + int'(code); m_na++; end
            else if (pm) m_op = int'(code) - 9;
            else if (eq) begin m_strobe = 1; m_busy = 2; end
         end else begin
            if (dig) begin m_a = int'(code); m_na = 1; m_b = 0; m_err = 0; m_mode = 0; end
            else if (pm && !m_err) begin m_a = m_cap; m_b = 0; m_na = 0; m_op = int'(code) - 9; m_mode = 1; end
            else if (eq) begin m_strobe = 1; m_busy = 2; end
         end
      end
      if (m_busy == 0)
         m_disp = m_mode == 0 ? to_bcd(m_a) : m_mode == 1 ? to_bcd(m_b) : m_err ? '1 : to_bcd(m_cap);
   endtask

   task automatic check_all();
      check("numero_1", 32'(numero_1), 32'(to_bcd(m_a)));
      check("numero_2", 32'(numero_2), 32'(to_bcd(m_b)));
      check("suma_resta", 32'(suma_resta), m_op == 0 ? 32'd0 : m_op == 1 ? 32'd2 : 32'd3);
      check("igual_en", 32'(igual_en), 32'(m_strobe));
      check("display", 32'(display), 32'(m_disp));
      check("error", 32'(error), 32'(m_err));
      check("busy", 32'(busy), 32'(m_busy > 0));
   endtask

   task automatic tick(input logic kv, input logic [3:0] code);
      key_valid = kv;
      key_code = code;
      resultado = to_bcd(m_res);
      @(posedge clk);
      model_step(kv, code);
      #1 check_all();
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; key_valid = 1'b0; key_code = '0; operacion_valida = 1'b1; m_res = 0;
      resultado = '0;
      model_clear();
      #12 check_all();
      @(negedge clk) reset = 1'b1;
      tick(1, 1); tick(1, 2); tick(1, 10); tick(1, 3); tick(1, 4); tick(1, 12);
      check("strobe_on_eq", 32'(igual_en), 32'd1);
      m_res = 46; operacion_valida = 1'b1;
      tick(0, 0);
      check("strobe_one_cycle", 32'(igual_en), 32'd0);
      tick(0, 0);
      check("sum_n1", 32'(numero_1), 32'h0012);
      check("sum_n2", 32'(numero_2), 32'h0034);
      check("sum_op", 32'(suma_resta), 32'h2);
      check("sum_disp", 32'(display), 32'h0046);
      tick(1, 10); tick(1, 5); tick(1, 12);
      check("chain_n1", 32'(numero_1), 32'h0046);
      check("chain_n2", 32'(numero_2), 32'h0005);
      check("chain_strobe", 32'(igual_en), 32'd1);
      m_res = 51; operacion_valida = 1'b0;
      tick(0, 0); tick(0, 0);
      check("err_flag", 32'(error), 32'd1);
      check("err_disp", 32'(display), 32'hFFFF);
      tick(1, 10);
      check("err_plus_ignored", 32'(display), 32'hFFFF);
      tick(1, 7);
      check("err_digit_n1", 32'(numero_1), 32'h0007);
      check("err_digit_clr", 32'(error), 32'd0);
      tick(1, 13);
      tick(1, 1); tick(1, 2); tick(1, 3); tick(1, 4); tick(1, 5);
      check("five_digits", 32'(numero_1), 32'h1234);
      tick(1, 11); tick(1, 9); tick(1, 12);
      check("sub_op", 32'(suma_resta), 32'h3);
      check("sub_n2", 32'(numero_2), 32'h0009);
      tick(1, 8);
      check("drop_in_issue", 32'(numero_2), 32'h0009);
      tick(1, 13);
      check("clr_wait_n1", 32'(numero_1), 32'h0);
      check("clr_wait_err", 32'(error), 32'd0);
      check("clr_wait_busy", 32'(busy), 32'd0);
      operacion_valida = 1'b1;
      tick(1, 1); tick(1, 10); tick(1, 2); tick(1, 12);
      #2 reset = 1'b0;
      #1 check("async_strobe", 32'(igual_en), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      model_clear();
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 600; i++) begin
         int r;
         logic [3:0] c;
         r = int'($urandom_range(0, 99));
         c = r < 55 ? 4'($urandom_range(0, 9)) : r < 75 ? 4'($urandom_range(10, 11)) :
             r < 90 ? 4'd12 : r < 93 ? 4'd13 : 4'($urandom_range(14, 15));
         m_res = int'($urandom_range(0, 9999));
         operacion_valida = $urandom_range(0, 3) != 0;
         tick(1'($urandom_range(0, 1)), c);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
